// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package writeback_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_result_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        reg_onehot    = '0;
        reg_onehot[r] = 1'b1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: pipeline result, LL result handshake, issue, decode query, RF write.
interface writeback_arbiter_if #(
    parameter int XLEN = 32
);
    logic            pipe_valid;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            pipe_stall;
    logic            ll_valid;
    logic            ll_ready;
    logic [4:0]      ll_rd;
    logic [XLEN-1:0] ll_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;

    modport master (
        output pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
               iss_valid, iss_rd, rs1_addr, rs2_addr,
        input  pipe_stall, ll_ready, rs1_busy, rs2_busy, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
               iss_valid, iss_rd, rs1_addr, rs2_addr,
        output pipe_stall, ll_ready, rs1_busy, rs2_busy, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// wb_sync_fifo: small synchronous FIFO with wrap-bit pointers; head is read combinationally.
module wb_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: pipeline result vs. queued long-latency results, plus scoreboard.
// Optional WB_FULL_STALL_EN: a full LL FIFO takes priority and stalls the pipeline.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int LL_FIFO_DEPTH = 4,
    parameter int XLEN          = writeback_arbiter_pkg::XLEN
) (
    input logic               clk,
    input logic               rst,
    writeback_arbiter_if.slave bus
);
    wb_result_t          ll_in, head;
    logic                push, pop, full, empty;
    logic                sel_pipe, stall_full;
    logic [NUM_REGS-1:0] pending, set_mask, clr_mask;
    logic                wr_en_q;
    logic [4:0]          wr_addr_q;
    logic [XLEN-1:0]     wr_data_q;

`ifdef WB_FULL_STALL_EN
    assign stall_full = full;
`else
    assign stall_full = 1'b0;
`endif

    assign ll_in          = '{rd: bus.ll_rd, data: bus.ll_data};
    assign bus.ll_ready   = !full;
    assign bus.pipe_stall = stall_full;
    assign push           = bus.ll_valid && !full;
    assign sel_pipe       = bus.pipe_valid && !stall_full;
    assign pop            = !sel_pipe && !empty;

    wb_sync_fifo #(
        .DEPTH (LL_FIFO_DEPTH),
        .WIDTH ($bits(wb_result_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (ll_in),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // x0 is never marked; OR-ing the set after the clear makes issue win over commit.
    assign set_mask = (bus.iss_valid && bus.iss_rd != '0) ? reg_onehot(bus.iss_rd) : '0;
    assign clr_mask = pop ? reg_onehot(head.rd) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~clr_mask) | set_mask;
    end

    assign bus.rs1_busy = pending[bus.rs1_addr] && (bus.rs1_addr != '0);
    assign bus.rs2_busy = pending[bus.rs2_addr] && (bus.rs2_addr != '0);

    // A selected rd==0 result is consumed but never raises wr_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (sel_pipe) begin
            wr_en_q   <= (bus.pipe_rd != '0);
            wr_addr_q <= bus.pipe_rd;
            wr_data_q <= bus.pipe_data;
        end else if (pop) begin
            wr_en_q   <= (head.rd != '0);
            wr_addr_q <= head.rd;
            wr_data_q <= head.data;
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed, table-driven bench for writeback_arbiter (default and WB_FULL_STALL_EN builds).
module tb_writeback_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    writeback_arbiter_if #(.XLEN(32)) bus ();

    writeback_arbiter #(.LL_FIFO_DEPTH(4), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        pv;
        bit [4:0]  prd;
        bit [31:0] pd;
        bit        lv;
        bit [4:0]  lrd;
        bit [31:0] ld;
        bit        iv;
        bit [4:0]  ird;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit        rdy;   // ll_ready before the edge
        bit        stall; // pipe_stall before the edge
        bit        wen;   // after the edge
        bit [4:0]  wa;
        bit [31:0] wd;
        bit        b1;
        bit        b2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit pv, bit [4:0] prd, bit [31:0] pd, bit lv, bit [4:0] lrd,
                                bit [31:0] ld, bit iv, bit [4:0] ird, bit [4:0] rs1, bit [4:0] rs2,
                                bit rdy, bit stall, bit wen, bit [4:0] wa, bit [31:0] wd,
                                bit b1, bit b2);
        vec_t x;
        x.pv = pv; x.prd = prd; x.pd = pd; x.lv = lv; x.lrd = lrd; x.ld = ld;
        x.iv = iv; x.ird = ird; x.rs1 = rs1; x.rs2 = rs2; x.rdy = rdy; x.stall = stall;
        x.wen = wen; x.wa = wa; x.wd = wd; x.b1 = b1; x.b2 = b2;
        return x;
    endfunction

    // Burst rows: pipe data = A0000000|rd, LL data = B0000000|rd, LL rds are 20 and up.
    function automatic vec_t mk3(bit pv, bit [4:0] prd, bit lv, bit [4:0] lrd,
                                 bit rdy, bit stall, bit wen, bit [4:0] wa);
        bit [31:0] wd;
        wd = (wa >= 5'd20) ? (32'hB000_0000 | 32'(wa)) : (32'hA000_0000 | 32'(wa));
        return mk(pv, prd, 32'hA000_0000 | 32'(prd), lv, lrd, 32'hB000_0000 | 32'(lrd),
                  0, 0, 0, 0, rdy, stall, wen, wa, wd, 0, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input vec_t x);
        bus.pipe_valid = x.pv;  bus.pipe_rd = x.prd; bus.pipe_data = x.pd;
        bus.ll_valid   = x.lv;  bus.ll_rd   = x.lrd; bus.ll_data   = x.ld;
        bus.iss_valid  = x.iv;  bus.iss_rd  = x.ird;
        bus.rs1_addr   = x.rs1; bus.rs2_addr = x.rs2;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0, 0,0,0, 0,0, 0,0, 1,0, 0,0,0, 0,0);
        drive(idle);

        // pipeline latency, LL latency with scoreboard, rd==0, set-wins, WAW, pipe priority
        vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0,      0,0, 7,0, 1,0, 1,5,32'hDEADBEEF, 0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,      1,7, 7,0, 1,0, 0,0,0,            1,0));
        vecs.push_back(mk(0,0,0,            1,7,32'h12, 0,0, 7,7, 1,0, 0,0,0,            1,1));
        vecs.push_back(mk(0,0,0,            0,0,0,      0,0, 7,7, 1,0, 1,7,32'h12,       0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,      0,0, 7,0, 1,0, 0,0,0,            0,0));
        vecs.push_back(mk(1,0,32'h55,       1,0,32'h66, 1,0, 0,0, 1,0, 0,0,0,            0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,      0,0, 0,0, 1,0, 0,0,0,            0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,      0,0, 0,0, 1,0, 0,0,0,            0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,      1,9, 9,0, 1,0, 0,0,0,            1,0));
        vecs.push_back(mk(0,0,0,            1,9,32'h99, 0,0, 9,0, 1,0, 0,0,0,            1,0));
        vecs.push_back(mk(0,0,0,            0,0,0,      1,9, 9,0, 1,0, 1,9,32'h99,       1,0));
        vecs.push_back(mk(0,0,0,            0,0,0,      0,0, 9,0, 1,0, 0,0,0,            1,0));
        vecs.push_back(mk(1,9,32'hAA,       0,0,0,      0,0, 9,0, 1,0, 1,9,32'hAA,       1,0));
        vecs.push_back(mk(0,0,0,            1,9,32'hBB, 0,0, 9,0, 1,0, 0,0,0,            1,0));
        vecs.push_back(mk(0,0,0,            0,0,0,      0,0, 9,0, 1,0, 1,9,32'hBB,       0,0));
        vecs.push_back(mk(0,0,0,            1,3,32'h33, 0,0, 0,0, 1,0, 0,0,0,            0,0));
        vecs.push_back(mk(1,4,32'h44,       0,0,0,      0,0, 0,0, 1,0, 1,4,32'h44,       0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,      0,0, 0,0, 1,0, 1,3,32'h33,       0,0));
        vecs.push_back(mk(0,0,0,            0,0,0,      0,0, 0,0, 1,0, 0,0,0,            0,0));

        // pipe busy for 6 results while the LL unit offers 5 results into a 4-deep FIFO
`ifdef WB_FULL_STALL_EN
        vecs.push_back(mk3(1,10, 1,20, 1,0, 1,10));
        vecs.push_back(mk3(1,11, 1,21, 1,0, 1,11));
        vecs.push_back(mk3(1,12, 1,22, 1,0, 1,12));
        vecs.push_back(mk3(1,13, 1,23, 1,0, 1,13));
        vecs.push_back(mk3(1,14, 1,24, 0,1, 1,20));
        vecs.push_back(mk3(1,14, 1,24, 1,0, 1,14));
        vecs.push_back(mk3(1,15, 0,0,  0,1, 1,21));
        vecs.push_back(mk3(1,15, 0,0,  1,0, 1,15));
        vecs.push_back(mk3(0,0,  0,0,  1,0, 1,22));
        vecs.push_back(mk3(0,0,  0,0,  1,0, 1,23));
        vecs.push_back(mk3(0,0,  0,0,  1,0, 1,24));
        vecs.push_back(mk3(0,0,  0,0,  1,0, 0,0));
`else
        vecs.push_back(mk3(1,10, 1,20, 1,0, 1,10));
        vecs.push_back(mk3(1,11, 1,21, 1,0, 1,11));
        vecs.push_back(mk3(1,12, 1,22, 1,0, 1,12));
        vecs.push_back(mk3(1,13, 1,23, 1,0, 1,13));
        vecs.push_back(mk3(1,14, 1,24, 0,0, 1,14));
        vecs.push_back(mk3(1,15, 1,24, 0,0, 1,15));
        vecs.push_back(mk3(0,0,  1,24, 0,0, 1,20));
        vecs.push_back(mk3(0,0,  1,24, 1,0, 1,21));
        vecs.push_back(mk3(0,0,  0,0,  1,0, 1,22));
        vecs.push_back(mk3(0,0,  0,0,  1,0, 1,23));
        vecs.push_back(mk3(0,0,  0,0,  1,0, 1,24));
        vecs.push_back(mk3(0,0,  0,0,  1,0, 0,0));
`endif

        // reset state
        bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst wr_en", 32'(bus.wr_en), 0);
        chk("rst wr_addr", 32'(bus.wr_addr), 0);
        chk("rst wr_data", bus.wr_data, 0);
        chk("rst ll_ready", 32'(bus.ll_ready), 1);
        chk("rst pipe_stall", 32'(bus.pipe_stall), 0);
        chk("rst rs1_busy", 32'(bus.rs1_busy), 0);
        chk("rst rs2_busy", 32'(bus.rs2_busy), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d ll_ready", i), 32'(bus.ll_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d pipe_stall", i), 32'(bus.pipe_stall), 32'(vecs[i].stall));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wr_en", i), 32'(bus.wr_en), 32'(vecs[i].wen));
            if (vecs[i].wen) begin
                chk($sformatf("v%0d wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].wa));
                chk($sformatf("v%0d wr_data", i), bus.wr_data, vecs[i].wd);
            end
            chk($sformatf("v%0d rs1_busy", i), 32'(bus.rs1_busy), 32'(vecs[i].b1));
            chk($sformatf("v%0d rs2_busy", i), 32'(bus.rs2_busy), 32'(vecs[i].b2));
        end

        // async reset with three LL results queued behind a busy pipeline
        for (int k = 0; k < 4; k++) begin
            vec_t x;
            @(negedge clk);
            x = idle;
            x.pv = 1; x.prd = 5'(k + 1); x.pd = 32'hC000_0000 | 32'(k);
            if (k < 3) begin
                x.lv = 1; x.lrd = 5'(11 + k); x.ld = 32'hD000_0000 | 32'(k);
                x.iv = 1; x.ird = 5'(11 + k);
            end
            x.rs1 = 5'd11; x.rs2 = 5'd13;
            drive(x);
        end
        @(posedge clk);
        #1;
        chk("pre-rst wr_en", 32'(bus.wr_en), 1);
        chk("pre-rst wr_addr", 32'(bus.wr_addr), 4);
        chk("pre-rst rs1_busy", 32'(bus.rs1_busy), 1);
        chk("pre-rst rs2_busy", 32'(bus.rs2_busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("async rst wr_en", 32'(bus.wr_en), 0);
        chk("async rst wr_data", bus.wr_data, 0);
        chk("async rst ll_ready", 32'(bus.ll_ready), 1);
        chk("async rst rs1_busy", 32'(bus.rs1_busy), 0);
        chk("async rst rs2_busy", 32'(bus.rs2_busy), 0);
        drive(idle);
        bus.rs1_addr = 5'd11; bus.rs2_addr = 5'd13;
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-rst c%0d wr_en", k), 32'(bus.wr_en), 0);
            chk($sformatf("post-rst c%0d rs1_busy", k), 32'(bus.rs1_busy), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
